// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for the motion-estimation core: walks every macroblock in raster
// order through window load, ME run (with watchdog) and a valid/ready result handshake.
module me_frame_scheduler #(
    parameter int unsigned FRAME_W_MB = 4,
    parameter int unsigned FRAME_H_MB = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start_i,
    input  logic        frame_abort_i,
    output logic        win_req_o,
    input  logic        win_ack_i,
    input  logic        me_ready_i,
    output logic        me_start_o,
    input  logic        me_done_i,
    input  logic [5:0]  me_mv_x_i,
    input  logic [5:0]  me_mv_y_i,
    input  logic [15:0] me_min_sad_i,
    output logic [7:0]  mb_x_o,
    output logic [7:0]  mb_y_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [5:0]  res_mv_x_o,
    output logic [5:0]  res_mv_y_o,
    output logic [15:0] res_sad_o,
    output logic        res_err_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned WdW = $clog2(TIMEOUT) + 1;
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [7:0] LastX = 8'(FRAME_W_MB - 1);
    localparam logic [7:0] LastY = 8'(FRAME_H_MB - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StArm,
        StRun,
        StEmit,
        StFin
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     mb_x_q, mb_x_d;
    logic [7:0]     mb_y_q, mb_y_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic [5:0]     res_mv_x_q, res_mv_x_d;
    logic [5:0]     res_mv_y_q, res_mv_y_d;
    logic [15:0]    res_sad_q, res_sad_d;
    logic           res_err_q, res_err_d;
    logic           win_req_q, win_req_d;
    logic           me_start_q, me_start_d;
    logic           res_valid_q, res_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        wd_d       = wd_q;
        res_mv_x_d = res_mv_x_q;
        res_mv_y_d = res_mv_y_q;
        res_sad_d  = res_sad_q;
        res_err_d  = res_err_q;

        // Abort overrides everything, including a handshake or capture in the same cycle.
        if (frame_abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (frame_start_i) begin
                        state_d = StLoad;
                        mb_x_d  = 8'd0;
                        mb_y_d  = 8'd0;
                    end
                end
                StLoad: begin
                    if (win_ack_i) state_d = StArm;
                end
                StArm: begin
                    if (me_ready_i) begin
                        state_d = StRun;
                        wd_d    = '0;
                    end
                end
                StRun: begin
                    if (me_done_i) begin
                        res_mv_x_d = me_mv_x_i;
                        res_mv_y_d = me_mv_y_i;
                        res_sad_d  = me_min_sad_i;
                        res_err_d  = 1'b0;
                        state_d    = StEmit;
                    end else if (wd_q == WdLast) begin
                        res_mv_x_d = 6'd0;
                        res_mv_y_d = 6'd0;
                        res_sad_d  = 16'hFFFF;
                        res_err_d  = 1'b1;
                        state_d    = StEmit;
                    end else if (wd_q != '1) begin
                        wd_d = wd_q + WdW'(1);
                    end
                end
                StEmit: begin
                    if (res_ready_i) begin
                        if ((mb_x_q == LastX) && (mb_y_q == LastY)) begin
                            state_d = StFin;
                        end else begin
                            state_d = StLoad;
                            if (mb_x_q == LastX) begin
                                mb_x_d = 8'd0;
                                mb_y_d = mb_y_q + 8'd1;
                            end else begin
                                mb_x_d = mb_x_q + 8'd1;
                            end
                        end
                    end
                end
                StFin: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // All handshake/status outputs are registered copies of the next state.
        win_req_d    = (state_d == StLoad);
        me_start_d   = (state_q == StArm) && (state_d == StRun);
        res_valid_d  = (state_d == StEmit);
        frame_done_d = (state_d == StFin);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mb_x_q       <= 8'd0;
            mb_y_q       <= 8'd0;
            wd_q         <= '0;
            res_mv_x_q   <= 6'd0;
            res_mv_y_q   <= 6'd0;
            res_sad_q    <= 16'd0;
            res_err_q    <= 1'b0;
            win_req_q    <= 1'b0;
            me_start_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mb_x_q       <= mb_x_d;
            mb_y_q       <= mb_y_d;
            wd_q         <= wd_d;
            res_mv_x_q   <= res_mv_x_d;
            res_mv_y_q   <= res_mv_y_d;
            res_sad_q    <= res_sad_d;
            res_err_q    <= res_err_d;
            win_req_q    <= win_req_d;
            me_start_q   <= me_start_d;
            res_valid_q  <= res_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign win_req_o    = win_req_q;
    assign me_start_o   = me_start_q;
    assign mb_x_o       = mb_x_q;
    assign mb_y_o       = mb_y_q;
    assign res_valid_o  = res_valid_q;
    assign res_mv_x_o   = res_mv_x_q;
    assign res_mv_y_o   = res_mv_y_q;
    assign res_sad_o    = res_sad_q;
    assign res_err_o    = res_err_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Bench for me_frame_scheduler: a scripted loader/ME/sink environment whose per-macroblock
// plan fixes the expected results, positions and handshake timing.
module tb_me_frame_scheduler;

    localparam int W  = 3;
    localparam int H  = 2;
    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        frame_start, frame_abort;
    logic        win_req, win_ack;
    logic        me_ready, me_start, me_done;
    logic [5:0]  me_mv_x, me_mv_y;
    logic [15:0] me_min_sad;
    logic [7:0]  mb_x, mb_y;
    logic        res_valid, res_ready;
    logic [5:0]  res_mv_x, res_mv_y;
    logic [15:0] res_sad;
    logic        res_err, busy, frame_done;

    me_frame_scheduler #(
        .FRAME_W_MB (W),
        .FRAME_H_MB (H),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start),
        .frame_abort_i (frame_abort),
        .win_req_o     (win_req),
        .win_ack_i     (win_ack),
        .me_ready_i    (me_ready),
        .me_start_o    (me_start),
        .me_done_i     (me_done),
        .me_mv_x_i     (me_mv_x),
        .me_mv_y_i     (me_mv_y),
        .me_min_sad_i  (me_min_sad),
        .mb_x_o        (mb_x),
        .mb_y_o        (mb_y),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_mv_x_o    (res_mv_x),
        .res_mv_y_o    (res_mv_y),
        .res_sad_o     (res_sad),
        .res_err_o     (res_err),
        .busy_o        (busy),
        .frame_done_o  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        int          done_dly;  // cycles after me_start; >= TO means ME never answers in time
        int          hold;
        logic [5:0]  mvx;
        logic [5:0]  mvy;
        logic [15:0] sad;
        bit          arm_noise;
        bit          load_start;
    } mb_plan_t;

    function automatic mb_plan_t make_plan(input int mode, input int idx);
        mb_plan_t p;
        int r;
        p.ack_dly    = int'($urandom_range(0, 3));
        p.rdy_dly    = int'($urandom_range(0, 3));
        p.hold       = int'($urandom_range(0, 4));
        p.mvx        = 6'($urandom);
        p.mvy        = 6'($urandom);
        p.sad        = 16'($urandom);
        p.arm_noise  = 1'($urandom);
        p.load_start = 1'($urandom);
        r            = int'($urandom_range(0, 9));
        p.done_dly   = (r == 0) ? TO - 1 : (r == 1) ? TO + 5 : int'($urandom_range(0, 8));
        if (mode == 1) begin
            p.ack_dly    = 0;
            p.rdy_dly    = (idx == 0) ? 7 : 0;
            p.hold       = (idx == 0) ? 10 : 0;
            p.done_dly   = (idx == 1) ? TO : (idx == 2) ? TO - 1 : 5;
            p.arm_noise  = (idx == 4);
            p.load_start = (idx == 3);
            if (idx == 0) begin
                p.mvx = 6'h03;
                p.mvy = 6'h3E;
                p.sad = 16'h0123;
            end
        end
        return p;
    endfunction

    task automatic junk_me();
        me_mv_x    = 6'($urandom);
        me_mv_y    = 6'($urandom);
        me_min_sad = 16'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"}, 32'(win_req), 0);
        check_eq({tag, "_start"}, 32'(me_start), 0);
        check_eq({tag, "_valid"}, 32'(res_valid), 0);
        check_eq({tag, "_done"}, 32'(frame_done), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    // mode 0: random plan, mode 1: directed plan. abort_mb/rst_mb pick a macroblock index
    // whose RUN (abort) or EMIT (reset) gets interrupted; -1 disables.
    task automatic run_frame(input int mode, input int abort_mb, input int rst_mb);
        mb_plan_t    p;
        int          idx, j;
        bit          end_run, exp_err;
        logic [5:0]  exp_mvx, exp_mvy;
        logic [15:0] exp_sad;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                idx = y * W + x;
                p   = make_plan(mode, idx);
                check_eq("load_req", 32'(win_req), 1);
                check_eq("load_x", 32'(mb_x), x);
                check_eq("load_y", 32'(mb_y), y);
                check_eq("load_busy", 32'(busy), 1);
                for (int k = 0; k < p.ack_dly; k++) begin
                    frame_start = p.load_start;
                    step();
                    frame_start = 1'b0;
                    check_eq("load_req_hold", 32'(win_req), 1);
                    check_eq("load_x_hold", 32'(mb_x), x);
                    check_eq("load_y_hold", 32'(mb_y), y);
                end
                win_ack = 1'b1;
                step();
                win_ack = 1'b0;
                check_eq("req_drop", 32'(win_req), 0);
                check_eq("arm_start", 32'(me_start), 0);
                for (int k = 0; k < p.rdy_dly; k++) begin
                    me_done = p.arm_noise;
                    junk_me();
                    step();
                    me_done = 1'b0;
                    check_eq("arm_wait_start", 32'(me_start), 0);
                end
                me_ready = 1'b1;
                step();
                me_ready = 1'b0;
                check_eq("start_pulse", 32'(me_start), 1);
                if (abort_mb == idx) begin
                    frame_abort = 1'b1;
                    step();
                    frame_abort = 1'b0;
                    check_quiet("abort");
                    return;
                end
                j = 0;
                while (1) begin
                    me_done = (j == p.done_dly);
                    if (me_done) begin
                        me_mv_x    = p.mvx;
                        me_mv_y    = p.mvy;
                        me_min_sad = p.sad;
                    end else begin
                        junk_me();
                    end
                    end_run = (j == p.done_dly) || (j == TO - 1);
                    step();
                    me_done = 1'b0;
                    if (end_run) break;
                    check_eq("run_valid", 32'(res_valid), 0);
                    if (j == 0) check_eq("start_once", 32'(me_start), 0);
                    j++;
                end
                exp_err = (p.done_dly > TO - 1);
                exp_mvx = exp_err ? 6'd0 : p.mvx;
                exp_mvy = exp_err ? 6'd0 : p.mvy;
                exp_sad = exp_err ? 16'hFFFF : p.sad;
                check_eq("res_valid", 32'(res_valid), 1);
                check_eq("res_mv_x", 32'(res_mv_x), 32'(exp_mvx));
                check_eq("res_mv_y", 32'(res_mv_y), 32'(exp_mvy));
                check_eq("res_sad", 32'(res_sad), 32'(exp_sad));
                check_eq("res_err", 32'(res_err), 32'(exp_err));
                if (rst_mb == idx) begin
                    rst_n = 1'b0;
                    #1;
                    check_quiet("rst");
                    check_eq("rst_sad", 32'(res_sad), 0);
                    check_eq("rst_mv", 32'({res_mv_x, res_mv_y, res_err}), 0);
                    check_eq("rst_pos", 32'({mb_x, mb_y}), 0);
                    step();
                    rst_n = 1'b1;
                    return;
                end
                for (int k = 0; k < p.hold; k++) begin
                    junk_me();
                    step();
                    check_eq("hold_valid", 32'(res_valid), 1);
                    check_eq("hold_sad", 32'(res_sad), 32'(exp_sad));
                    check_eq("hold_mv", 32'({res_mv_x, res_mv_y, res_err}),
                             32'({exp_mvx, exp_mvy, exp_err}));
                    check_eq("hold_pos", 32'({mb_x, mb_y}), 32'({8'(x), 8'(y)}));
                    check_eq("hold_req", 32'(win_req), 0);
                end
                res_ready = 1'b1;
                step();
                res_ready = 1'b0;
                if (idx == W * H - 1) begin
                    check_eq("fin_done", 32'(frame_done), 1);
                    check_eq("fin_busy", 32'(busy), 1);
                    check_eq("fin_valid", 32'(res_valid), 0);
                    step();
                    check_eq("idle_done", 32'(frame_done), 0);
                    check_eq("idle_busy", 32'(busy), 0);
                    check_eq("final_pos", 32'({mb_x, mb_y}), 32'({8'(W - 1), 8'(H - 1)}));
                end else begin
                    check_eq("post_hs_valid", 32'(res_valid), 0);
                end
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        win_ack     = 1'b0;
        me_ready    = 1'b0;
        me_done     = 1'b0;
        res_ready   = 1'b0;
        me_mv_x     = 6'd0;
        me_mv_y     = 6'd0;
        me_min_sad  = 16'd0;
        step();
        step();
        check_quiet("reset");
        check_eq("reset_pos", 32'({mb_x, mb_y}), 0);
        check_eq("reset_res", 32'({res_mv_x, res_mv_y, res_sad, res_err}), 0);
        rst_n = 1'b1;
        step();
        check_quiet("idle");

        run_frame(1, -1, -1);
        step();
        for (int f = 0; f < 3; f++) begin
            run_frame(0, -1, -1);
            step();
        end
        run_frame(0, 1, -1);
        step();
        check_quiet("post_abort");
        run_frame(0, -1, -1);
        run_frame(0, -1, 2);
        check_quiet("post_rst");
        run_frame(0, -1, -1);
        step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/me_frame_scheduler.md
Name: me_frame_scheduler

Overview:
- Sequences the motion-estimation core across every macroblock of a frame in raster order.
- For each macroblock it:
  - requests a search-window load from the window loader;
  - arms the ME core with a one-cycle start pulse and waits for its done;
  - captures the motion vector and minimum SAD;
  - presents the result downstream on a valid/ready handshake.
- Sits between the frame-level encoder control, the search-window loader and the ME core.

Parameters:
- FRAME_W_MB, 4, frame width in macroblocks (1..255)
- FRAME_H_MB, 4, frame height in macroblocks (1..255)
- TIMEOUT, 1024, maximum cycles in RUN before the watchdog fires (≥2)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- frame_start  input  1  start frame; sampled only in IDLE
- frame_abort  input  1  abandon frame; return to IDLE
- win_req  output  1  search-window load request for (mb_x, mb_y)
- win_ack  input  1  window loaded; one-cycle pulse
- me_ready  input  1  ME core idle
- me_start  output  1  one-cycle ME start pulse
- me_done  input  1  ME core finished; one-cycle pulse
- me_mv_x  input  6  ME motion vector x
- me_mv_y  input  6  ME motion vector y
- me_min_sad  input  16  ME minimum SAD
- mb_x  output  8  current macroblock column
- mb_y  output  8  current macroblock row
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts result
- res_mv_x  output  6  captured mv_x
- res_mv_y  output  6  captured mv_y
- res_sad  output  16  captured SAD
- res_err  output  1  result produced by watchdog, not by ME
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
Reset:
- All outputs 0, state IDLE, counters 0.
- Asynchronous assertion takes effect immediately mid-operation; no result is emitted.

States: IDLE, LOAD, ARM, RUN, EMIT, FIN.
- IDLE:
  - frame_start=1 → LOAD next cycle.
  - mb_x and mb_y are cleared to 0 on that transition.
- LOAD:
  - win_req=1 for the whole state.
  - win_ack=1 → ARM.
  - win_req drops in the cycle after the ack.
- ARM:
  - When me_ready=1: me_start=1 for exactly one cycle, then → RUN.
  - Watchdog counter cleared on entry to RUN.
  - me_done seen in ARM is ignored.
- RUN:
  - me_done=1 → capture me_mv_x, me_mv_y, me_min_sad into res_* registers with res_err=0; → EMIT.
  - Watchdog counter reaching TIMEOUT-1 without me_done → res_mv_x=0, res_mv_y=0, res_sad=16'hFFFF, res_err=1; → EMIT.
  - me_done and watchdog expiry in the same cycle: me_done wins.
- EMIT:
  - res_valid=1; res_* are held stable until res_ready=1.
  - On handshake (res_valid & res_ready) in the last macroblock (mb_x=FRAME_W_MB-1, mb_y=FRAME_H_MB-1) → FIN.
  - On handshake otherwise, advance the position and → LOAD:
    - mb_x+1 normally;
    - at mb_x=FRAME_W_MB-1: mb_x wraps to 0 and mb_y+1.
- FIN:
  - frame_done=1 for one cycle → IDLE.
  - mb_x and mb_y keep their final values until the next frame_start.

Abort and frame_start rules:
- frame_abort=1 in any non-IDLE state → IDLE next cycle.
  - win_req, me_start and res_valid are forced 0 from that cycle.
  - No frame_done is produced.
  - frame_abort has priority over every other transition.
- frame_start outside IDLE is ignored; it is not queued.

Output timing:
- me_start, frame_done and res_valid are registered outputs.
- Minimum per-macroblock latency, from win_ack to res_valid, is 3 cycles (ARM, RUN, EMIT) when me_ready is already high.

Widths:
- Position counters are 8 bits. Parameters guarantee no overflow.
- The watchdog counter is $clog2(TIMEOUT)+1 bits and saturates.

Test Plan:
- FRAME_W_MB=2, FRAME_H_MB=2. frame_start, immediate acks, me_done 5 cycles after each start, res_ready=1 → four results in order (0,0),(1,0),(0,1),(1,1), each res_err=0; frame_done exactly one cycle after the 4th handshake; busy then low.
- ME returns mv_x=6'h3, mv_y=6'h3E, sad=16'h0123; res_ready held low 10 cycles → res_valid high with values stable for all 10 cycles; mb_x/mb_y do not advance and there is no win_req until res_ready.
- me_ready low for 7 cycles in ARM → me_start stays 0, then pulses exactly once within one cycle of me_ready rising.
- TIMEOUT=16 and me_done never arrives → res_valid after 16 RUN cycles with sad=16'hFFFF, mv=0, res_err=1; me_done landing on the expiry cycle instead → res_err=0 with the captured values.
- frame_abort asserted in RUN of macroblock (1,0) → IDLE next cycle with win_req, me_start, res_valid and frame_done all 0. A subsequent frame_start restarts at (0,0).
- rst_n pulsed low in EMIT → all outputs 0 asynchronously; frame_start during LOAD has no effect on the counters.
